// File: rtl/codec_pkg.sv
// codec_pkg: constants shared by the I2S transmit and receive paths.
// Latency: n/a (constants only).
// Backpressure: n/a.
//   DATA_W_DEF / SLOT_W_DEF : default sample width and BCLK periods per slot
//   LR_LEFT / LR_RIGHT      : lrclk level during the left / right slot
package codec_pkg;

   localparam int   DATA_W_DEF = 16;
   localparam int   SLOT_W_DEF = 32;

   localparam logic LR_LEFT    = 1'b0;
   localparam logic LR_RIGHT   = 1'b1;

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: derives BCLK/LRCLK from clk and flags the bclk falling-edge events.
// Latency: fall_evt/frame_evt are combinational and name the cycle whose clock edge drops bclk.
// Backpressure: none; free-running from reset release.
//   clk, rst     : system clock, synchronous active-low reset
//   bclk, lrclk  : registered bit clock and word select
//   fall_evt     : this cycle's edge takes bclk 1->0
//   frame_evt    : fall_evt on which the bit counter wraps to 0 (new frame)
//   bit_idx      : bit counter value before this fall event
module i2s_clkgen
   import codec_pkg::*;
#(
   parameter int  SLOT_W   = SLOT_W_DEF,
   parameter int  BCLK_DIV = 4,
   localparam int CNT_W    = $clog2(2 * SLOT_W)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             bclk,
   output logic             lrclk,
   output logic             fall_evt,
   output logic             frame_evt,
   output logic [CNT_W-1:0] bit_idx
);

   localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             div_tc;

   always_comb begin
      div_tc    = (div_q == DIV_W'(BCLK_DIV - 1));
      div_d     = div_tc ? '0 : div_q + DIV_W'(1);
      bclk_d    = div_tc ? ~bclk_q : bclk_q;
      fall_evt  = div_tc && bclk_q;
      frame_evt = fall_evt && (cnt_q == CNT_LAST);
      cnt_d     = cnt_q;
      lrclk_d   = lrclk_q;
      if (fall_evt) begin
         cnt_d = frame_evt ? '0 : cnt_q + CNT_W'(1);
         if (frame_evt) begin
            lrclk_d = LR_LEFT;
         end else if (cnt_q == CNT_W'(SLOT_W - 1)) begin
            lrclk_d = LR_RIGHT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q   <= '0;
         cnt_q   <= CNT_LAST;
         bclk_q  <= 1'b0;
         lrclk_q <= LR_RIGHT;
      end else begin
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
      end
   end

   assign bclk    = bclk_q;
   assign lrclk   = lrclk_q;
   assign bit_idx = cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter with a one-frame holding buffer for signed stereo samples.
// Latency: a pair accepted before a frame start goes out in that frame; L MSB one BCLK after lrclk falls.
// Backpressure: sample_ready low while the buffer is full; lossless, empties at each frame start.
//   clk, rst                     : system clock, synchronous active-low reset
//   sample_l/_r, sample_valid    : upstream stereo pair, taken when sample_valid && sample_ready
//   sample_ready                 : holding buffer empty
//   bclk, lrclk, sdata           : I2S bus to the codec (sdata changes on bclk falling edge)
//   frame_start, underrun        : one-clk pulses on frame load / frame load with empty buffer
// Build option I2S_TX_REPEAT_EN: an underrun frame repeats the last transmitted pair
// instead of sending zeros.
module i2s_tx
   import codec_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SLOT_W   = SLOT_W_DEF,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_l,
   input  logic [DATA_W-1:0] sample_r,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              frame_start,
   output logic              underrun
);

   localparam int FRAME_W = 2 * SLOT_W;
   localparam int CNT_W   = $clog2(FRAME_W);

   logic              fall_evt, frame_evt;
   logic [CNT_W-1:0]  bit_idx;

   logic              buf_full_q, buf_full_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic              sdata_q, sdata_d;
   logic              frame_start_q, frame_start_d;
   logic              underrun_q, underrun_d;

   logic              xfer;
   logic [DATA_W-1:0] fill_l, fill_r;
   logic [SLOT_W-1:0] slot_l, slot_r;
   logic [CNT_W-1:0]  tx_sel;

`ifdef I2S_TX_REPEAT_EN
   logic [DATA_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

   i2s_clkgen #(
      .SLOT_W   (SLOT_W),
      .BCLK_DIV (BCLK_DIV)
   ) u_clkgen (
      .clk       (clk),
      .rst       (rst),
      .bclk      (bclk),
      .lrclk     (lrclk),
      .fall_evt  (fall_evt),
      .frame_evt (frame_evt),
      .bit_idx   (bit_idx)
   );

   always_comb begin
      buf_full_d    = buf_full_q;
      buf_l_d       = buf_l_q;
      buf_r_d       = buf_r_q;
      tx_d          = tx_q;
      sdata_d       = sdata_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      xfer          = sample_valid && !buf_full_q;
`ifdef I2S_TX_REPEAT_EN
      last_l_d      = last_l_q;
      last_r_d      = last_r_q;
      fill_l        = last_l_q;
      fill_r        = last_r_q;
`else
      fill_l        = '0;
      fill_r        = '0;
`endif

      // Slot image: sample MSB-aligned, remaining LSBs zero.
      slot_l = '0;
      slot_r = '0;
      slot_l[SLOT_W-1 -: DATA_W] = buf_full_q ? buf_l_q : fill_l;
      slot_r[SLOT_W-1 -: DATA_W] = buf_full_q ? buf_r_q : fill_r;

      // The frame register is indexed rather than shifted. On the frame
      // event bit_idx is the last count, selecting bit 0 of the outgoing
      // frame: that is the one-bit I2S delay into the next frame.
      tx_sel = CNT_W'(FRAME_W - 1) - bit_idx;
      if (fall_evt) begin
         sdata_d = tx_q[tx_sel];
      end

      if (frame_evt) begin
         tx_d          = {slot_l, slot_r};
         frame_start_d = 1'b1;
         underrun_d    = !buf_full_q;
         buf_full_d    = 1'b0;
`ifdef I2S_TX_REPEAT_EN
         if (buf_full_q) begin
            last_l_d = buf_l_q;
            last_r_d = buf_r_q;
         end
`endif
      end

      // Only possible with the buffer empty, so an empty-buffer frame start
      // in the same cycle has already taken fill data; this pair waits.
      if (xfer) begin
         buf_l_d    = sample_l;
         buf_r_d    = sample_r;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_full_q    <= 1'b0;
         buf_l_q       <= '0;
         buf_r_q       <= '0;
         tx_q          <= '0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
`ifdef I2S_TX_REPEAT_EN
         last_l_q      <= '0;
         last_r_q      <= '0;
`endif
      end else begin
         buf_full_q    <= buf_full_d;
         buf_l_q       <= buf_l_d;
         buf_r_q       <= buf_r_d;
         tx_q          <= tx_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
`ifdef I2S_TX_REPEAT_EN
         last_l_q      <= last_l_d;
         last_r_q      <= last_r_d;
`endif
      end
   end

   assign sample_ready = !buf_full_q;
   assign sdata        = sdata_q;
   assign frame_start  = frame_start_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized stimulus for i2s_tx with a frame-level scoreboard.
// Latency: expected frames are queued at their load cycle and matched when the decoded frame completes.
// Backpressure: the driver holds sample_valid until the bench's own buffer model accepts the pair.
module tb_i2s_tx;

   localparam int DW        = 16;
   localparam int SLOT      = 32;
   localparam int BDIV      = 4;
   localparam int FRAME_CYC = 4 * SLOT * BDIV;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] sample_l, sample_r;
   logic          sample_valid;
   logic          sample_ready, bclk, lrclk, sdata, frame_start, underrun;

   i2s_tx #(.DATA_W(DW), .SLOT_W(SLOT), .BCLK_DIV(BDIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;   // clk edges since the last edge that saw reset
   int frames_dec = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model: I2S timing from the frame rules ----------------
   function automatic logic exp_bclk(input int c);
      return ((c / BDIV) % 2) == 1;
   endfunction

   function automatic logic exp_lrclk(input int c);
      if (c < 2 * BDIV) return 1'b1;
      return ((c - 2 * BDIV) % FRAME_CYC) >= (FRAME_CYC / 2);
   endfunction

   function automatic bit is_frame_edge(input int e);
      return (e >= 2 * BDIV) && (((e - 2 * BDIV) % FRAME_CYC) == 0);
   endfunction

   function automatic logic [63:0] frame_of(input logic [DW-1:0] l, input logic [DW-1:0] r);
      return {l, 16'h0000, r, 16'h0000};
   endfunction

   logic [63:0]   exp_q[$];
   logic          m_full = 1'b0;
   logic [DW-1:0] m_l = '0, m_r = '0, m_last_l = '0, m_last_r = '0;
   logic          exp_fs = 1'b0, exp_ur = 1'b0, xfer_seen = 1'b0, mon_en = 1'b0;

   always @(posedge clk) begin
      mon_en <= 1'b1;
      if (!rst) begin
         cyc       <= 0;
         m_full    <= 1'b0;
         m_last_l  <= '0;
         m_last_r  <= '0;
         exp_fs    <= 1'b0;
         exp_ur    <= 1'b0;
         xfer_seen <= 1'b0;
         exp_q.delete();
      end else begin
         cyc       <= cyc + 1;
         exp_fs    <= is_frame_edge(cyc + 1);
         exp_ur    <= is_frame_edge(cyc + 1) && !m_full;
         xfer_seen <= sample_valid && !m_full;
         if (is_frame_edge(cyc + 1)) begin
            if (m_full) begin
               exp_q.push_back(frame_of(m_l, m_r));
               m_last_l <= m_l;
               m_last_r <= m_r;
               m_full   <= 1'b0;
            end else begin
`ifdef I2S_TX_REPEAT_EN
               exp_q.push_back(frame_of(m_last_l, m_last_r));
`else
               exp_q.push_back(64'h0);
`endif
            end
         end
         if (sample_valid && !m_full) begin
            m_l    <= sample_l;
            m_r    <= sample_r;
            m_full <= 1'b1;
         end
      end
   end

   // ---------------- monitor: pin checks and I2S decoder ----------------
   logic [63:0] dec = '0;
   int          dec_n = 0;
   logic        dec_on = 1'b0, prev_lr = 1'b1, prev_bclk = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("bclk", 64'(bclk), 64'(exp_bclk(cyc)));
         chk("lrclk", 64'(lrclk), 64'(exp_lrclk(cyc)));
         chk("sample_ready", 64'(sample_ready), 64'(!m_full));
         chk("frame_start", 64'(frame_start), 64'(exp_fs));
         chk("underrun", 64'(underrun), 64'(exp_ur));
         if (cyc == 0) chk("rst_sdata", 64'(sdata), 64'h0);

         if (!rst) begin
            dec_on    <= 1'b0;
            dec_n     <= 0;
            prev_lr   <= 1'b1;
            prev_bclk <= 1'b0;
         end else begin
            prev_bclk <= bclk;
            if (bclk && !prev_bclk) begin
               prev_lr <= lrclk;
               if (!lrclk && prev_lr) begin
                  // n=0 sample: closes the previous frame with its delayed last bit.
                  if (dec_on && dec_n == 63) begin
                     frames_dec <= frames_dec + 1;
                     if (exp_q.size() == 0) chk("frame_unexpected", {dec[62:0], sdata}, 64'hx);
                     else                   chk("frame", {dec[62:0], sdata}, exp_q.pop_front());
                  end
                  dec_on <= 1'b1;
                  dec_n  <= 0;
               end else if (dec_on) begin
                  dec   <= {dec[62:0], sdata};
                  dec_n <= dec_n + 1;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (!sample_valid) begin
            sample_l = DW'($urandom);
            sample_r = DW'($urandom);
         end
      end
   endtask

   task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit hold);
      int n = 0;
      sample_l     = l;
      sample_r     = r;
      sample_valid = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!xfer_seen && n < 2 * FRAME_CYC);
      chk("send_accept", 64'(xfer_seen), 64'h1);
      if (!hold) sample_valid = 1'b0;
   endtask

   // Wait until the cycle that is ph clk edges after a frame load.
   task automatic wait_phase(input int ph);
      int n = 0;
      while (!(cyc >= 2 * BDIV && ((cyc - 2 * BDIV) % FRAME_CYC) == ph) && n < 2 * FRAME_CYC) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("phase_wait", 64'(n < 2 * FRAME_CYC), 64'h1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic [DW-1:0] base;

   initial begin
      rst          = 1'b0;
      sample_valid = 1'b0;
      sample_l     = '0;
      sample_r     = '0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle: every frame underruns with zero data.
      idle(1100);

      // Directed pair accepted before the first frame.
      do_reset(3);
      send(16'h8001, 16'h7FFE, 1'b0);
      idle(1200);

      // Ramp with sample_valid held high: one transfer per frame.
      base = DW'($urandom);
      for (int i = 0; i < 8; i++) send(base + DW'(i), ~(base + DW'(i)), 1'b1);
      sample_valid = 1'b0;

      // Random gaps and data.
      for (int i = 0; i < 6; i++) begin
         idle(int'($urandom_range(0, 700)));
         send(DW'($urandom), DW'($urandom), 1'b0);
      end
      idle(600);

      // Transfer on the cycle of an empty-buffer frame load (underrun, pair kept).
      wait_phase(FRAME_CYC - 1);
      sample_l     = DW'($urandom);
      sample_r     = DW'($urandom);
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("edge_accept", 64'(xfer_seen), 64'h1);
      sample_valid = 1'b0;
      idle(600);

      // Transfer while frame_start is high.
      wait_phase(0);
      send(DW'($urandom), DW'($urandom), 1'b0);
      idle(600);

      // Reset in the middle of the left slot with a pair buffered.
      send(DW'($urandom), DW'($urandom), 1'b0);
      send(DW'($urandom), DW'($urandom), 1'b0);
      wait_phase(100);
      do_reset(1);
      idle(1100);

      // Single pair then silence: repeated or zero fill afterwards.
      send(16'h1234, 16'hABCD, 1'b0);
      idle(1700);

      chk("frames_decoded_enough", 64'(frames_dec >= 15), 64'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
